// File: rtl/ifu_npc.sv
// ifu_npc: instruction fetch unit with integrated next-PC selection.
// Owns the PC, fetches one word at a time over a valid/ready handshake,
// holds it in the instruction register until the core retires it, then
// moves the PC to the next-PC chosen by the decoder's NPCOp.
// Optional feature macro: IFU_PERF_CNT_EN (retired / stall perf counters).
module ifu_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic [1:0]  i_npc_op,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_perf_retired,
    output logic [31:0] o_perf_stall
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_req_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic        w_retire;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_retire   = (r_state == S_HOLD) && i_instr_ready;

    // Next-PC select; only consumed on the retire edge, so the operands
    // are effectively sampled in the S_HOLD cycle with instr_ready high.
    always_comb begin
        w_npc = w_pc_plus4;
        case (i_npc_op)
            NPC_PLUS4:  w_npc = w_pc_plus4;
            NPC_BRANCH: w_npc = w_pc_plus4 + w_br_off;
            NPC_JUMP:   w_npc = {w_pc_plus4[31:28], i_imm26, 2'b00};
            default:    w_npc = {i_rs_data[31:2], 2'b00};
        endcase
    end

    // Fetch FSM: request, wait for response, hold until retired.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_req_valid   <= 1'b1;
        end else begin
            case (r_state)
                S_REQ: begin
                    // A response seen here belongs to no live request; drop it.
                    if (i_imem_req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        r_instr       <= i_imem_rsp_data;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_instr_ready) begin
                        r_pc          <= w_npc;
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    r_state       <= S_REQ;
                    r_instr_valid <= 1'b0;
                    r_req_valid   <= 1'b1;
                end
            endcase
        end
    end

    assign o_imem_req_valid = r_req_valid;
    assign o_imem_addr      = r_pc;
    assign o_instr          = r_instr;
    assign o_instr_valid    = r_instr_valid;
    assign o_pc             = r_pc;
    assign o_pc_plus4       = w_pc_plus4;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    // Perf counters: retires, and cycles with no instruction available.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_retired <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_retire)
                r_perf_retired <= r_perf_retired + 32'd1;
            if (!r_instr_valid)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign o_perf_retired = r_perf_retired;
    assign o_perf_stall   = r_perf_stall;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign o_perf_retired  = 32'h0;
    assign o_perf_stall    = 32'h0;
`endif

endmodule
